// File: rtl/machine_ram_pkg.sv
// Shared encodings and field positions for the machine_ram memory responder.
package machine_ram_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE,
        S_ERR
    } state_e;

    localparam int REQ_W         = 95;
    localparam int STAT_W        = 65;
    localparam int REQ_OP_LSB    = 93;
    localparam int REQ_ADDR_LSB  = 61;
    localparam int REQ_WDATA_LSB = 29;
    localparam int REQ_BE_LSB    = 25;
    localparam int ECHO_W        = 31;

endpackage

// File: rtl/machine_ram_array.sv
// Single-port word array with byte write enables; a write returns the merged word.
module machine_ram_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        be_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] merged;

    always_comb begin
        merged = mem_q[addr_i];
        for (int unsigned b = 0; b < 4; b++) begin
            if (be_i[b]) merged[8*b +: 8] = wdata_i[8*b +: 8];
        end
    end

    // A read is an access with no byte enables, so merged is simply the stored word.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            mem_q[addr_i] <= merged;
            rdata_o       <= merged;
        end
    end

endmodule

// File: rtl/machine_ram.sv
// Memory responder: one outstanding request, LATENCY busy cycles, then DONE or ERROR.
module machine_ram
    import machine_ram_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              system1000,
    input  logic              system1000_rst,
    input  logic [REQ_W-1:0]  req,
    output logic [STAT_W-1:0] ramstatus
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY);

    op_e         req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        addr_ok;
    logic        unused_rsvd;

    assign req_op      = op_e'(req[REQ_OP_LSB +: 2]);
    assign req_addr    = req[REQ_ADDR_LSB +: 32];
    assign req_wdata   = req[REQ_WDATA_LSB +: 32];
    assign req_be      = req[REQ_BE_LSB +: 4];
    assign unused_rsvd = ^req[REQ_BE_LSB-1:0];
    assign addr_ok     = (req_addr[1:0] == 2'b00) && ((req_addr >> (ADDR_W + 2)) == 32'd0);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [ECHO_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         be_q, be_d;
    logic               wr_q, wr_d;
    logic               commit;
    logic [31:0]        arr_rdata;

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        wr_d      = wr_q;
        commit    = 1'b0;
        ramstatus = '0;
        case (state_q)
            S_IDLE: begin
                // Latch even on error so the ERROR cycle can echo the offending address.
                if (req_op != OP_NONE) begin
                    addr_d  = req_addr[ECHO_W-1:0];
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    wr_d    = (req_op == OP_WRITE);
                    cnt_d   = CNT_INIT;
                    state_d = (addr_ok && req_op != OP_RSVD) ? S_BUSY : S_ERR;
                end
            end
            S_BUSY: begin
                ramstatus = {ST_BUSY, 32'h0, addr_q};
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    commit  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ramstatus = {ST_DONE, arr_rdata, addr_q};
                state_d   = S_IDLE;
            end
            S_ERR: begin
                ramstatus = {ST_ERR, 32'h0, addr_q};
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    machine_ram_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (system1000),
        .en_i    (commit),
        .addr_i  (addr_q[ADDR_W+1:2]),
        .wdata_i (wdata_q),
        .be_i    ((commit && wr_q) ? be_q : 4'b0000),
        .rdata_o (arr_rdata)
    );

endmodule

// File: tb/tb_machine_ram.sv
// Self-checking bench for machine_ram: vector table plus hand-written corner sequences.
module tb_machine_ram;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [94:0] req;
    logic [64:0] rs;

    always #5 clk = ~clk;

    machine_ram #(
        .ADDR_W  (10),
        .LATENCY (LAT)
    ) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .req            (req),
        .ramstatus      (rs)
    );

    typedef struct {
        logic [64:0] val;
        logic [64:0] mask;
        int          tag;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [24:0] rsv;
        logic [1:0]  est;
        logic [31:0] edata;
    } vec_t;

    exp_t sb[$];
    vec_t vt[14];
    int   checks = 0;
    int   fails  = 0;

    function automatic logic [94:0] mkreq(logic [1:0] op, logic [31:0] a, logic [31:0] d,
                                          logic [3:0] be, logic [24:0] rsv);
        return {op, a, d, be, rsv};
    endfunction

    function automatic logic [64:0] mkst(logic [1:0] st, logic [31:0] d, logic [31:0] a);
        return {st, d, a[30:0]};
    endfunction

    // BUSY data is not defined, so only status and echo are compared there.
    task automatic push(input logic [1:0] st, input logic [31:0] d, input logic [31:0] a, input int tag);
        exp_t e;
        e.val  = mkst(st, d, a);
        e.mask = (st == 2'b01) ? {2'b11, 32'h0, 31'h7FFF_FFFF} : '1;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ((rs & e.mask) !== (e.val & e.mask)) begin
                fails++;
                $display("FAIL step%0d: ramstatus=%h expected=%h mask=%h", e.tag, rs, e.val, e.mask);
            end
        end
    endtask

    task automatic txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [24:0] rsv, input logic [1:0] est,
                       input logic [31:0] ed, input int tag);
        int n;
        req = mkreq(op, a, d, be, rsv);
        if (est == 2'b11) begin
            push(2'b11, 32'h0, a, tag);
            n = 1;
        end else begin
            for (int i = 0; i < LAT; i++) push(2'b01, 32'h0, a, tag);
            push(2'b10, ed, a, tag);
            n = LAT + 1;
        end
        repeat (n) tick();
        req = '0;
        push(2'b00, 32'h0, 32'h0, tag);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 25'h0,       2'b10, 32'hDEAD_BEEF};
        vt[1]  = '{2'b01, 32'h0000_0010, 32'h0,         4'b0000, 25'h0,       2'b10, 32'hDEAD_BEEF};
        vt[2]  = '{2'b10, 32'h0000_0010, 32'h1122_3344, 4'b0101, 25'h0,       2'b10, 32'hDE22_BE44};
        vt[3]  = '{2'b01, 32'h0000_0010, 32'h0,         4'b0000, 25'h0,       2'b10, 32'hDE22_BE44};
        vt[4]  = '{2'b01, 32'h0000_0012, 32'h0,         4'b0000, 25'h0,       2'b11, 32'h0};
        vt[5]  = '{2'b01, 32'h0000_1000, 32'h0,         4'b0000, 25'h0,       2'b11, 32'h0};
        vt[6]  = '{2'b11, 32'h0000_0010, 32'h0,         4'b1111, 25'h0,       2'b11, 32'h0};
        vt[7]  = '{2'b10, 32'h8000_0010, 32'h0BAD_0BAD, 4'b1111, 25'h0,       2'b11, 32'h0};
        vt[8]  = '{2'b01, 32'h0000_0010, 32'h0,         4'b0000, 25'h0,       2'b10, 32'hDE22_BE44};
        vt[9]  = '{2'b10, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 25'h1ABCDEF, 2'b10, 32'hDE22_BE44};
        vt[10] = '{2'b10, 32'h0000_0FFC, 32'h0A0B_0C0D, 4'b1111, 25'h1FFFFFF, 2'b10, 32'h0A0B_0C0D};
        vt[11] = '{2'b01, 32'h0000_0FFC, 32'h0,         4'b0000, 25'h0,       2'b10, 32'h0A0B_0C0D};
        vt[12] = '{2'b01, 32'h0000_0010, 32'h0,         4'b0000, 25'h0,       2'b10, 32'hDE22_BE44};
        vt[13] = '{2'b10, 32'h0000_0030, 32'h0,         4'b1111, 25'h0,       2'b10, 32'h0};

        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        push(2'b00, 32'h0, 32'h0, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) push(2'b00, 32'h0, 32'h0, 1);
        repeat (5) tick();

        for (int i = 0; i < 14; i++)
            txn(vt[i].op, vt[i].addr, vt[i].data, vt[i].be, vt[i].rsv, vt[i].est, vt[i].edata, 100 + i);

        // Request churn: write to 0x20 appears during the read's BUSY and is held past DONE.
        req = mkreq(2'b01, 32'h10, 32'h0, 4'b0000, 25'h0);
        for (int i = 0; i < LAT; i++) push(2'b01, 32'h0, 32'h10, 200);
        push(2'b10, 32'hDE22_BE44, 32'h10, 200);
        tick();
        req = mkreq(2'b10, 32'h20, 32'h5566_7788, 4'b1111, 25'h0);
        repeat (LAT) tick();
        push(2'b00, 32'h0, 32'h0, 201);
        tick();
        for (int i = 0; i < LAT; i++) push(2'b01, 32'h0, 32'h20, 202);
        push(2'b10, 32'h5566_7788, 32'h20, 202);
        repeat (LAT + 1) tick();
        req = '0;
        push(2'b00, 32'h0, 32'h0, 203);
        tick();
        txn(2'b01, 32'h10, 32'h0, 4'b0000, 25'h0, 2'b10, 32'hDE22_BE44, 204);
        txn(2'b01, 32'h20, 32'h0, 4'b0000, 25'h0, 2'b10, 32'h5566_7788, 205);

        // Reset during the first BUSY cycle of a write must drop it.
        req = mkreq(2'b10, 32'h30, 32'hCAFE_F00D, 4'b1111, 25'h0);
        push(2'b01, 32'h0, 32'h30, 300);
        tick();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (rs !== 65'h0) begin
            fails++;
            $display("FAIL async_reset: ramstatus=%h expected=%h", rs, 65'h0);
        end
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        push(2'b00, 32'h0, 32'h0, 301);
        tick();
        txn(2'b01, 32'h30, 32'h0, 4'b0000, 25'h0, 2'b10, 32'h0, 302);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
